// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Runs complete I2C register transactions (write or repeated-start read of
//   1..MAX_BYTES data bytes) on top of a byte-level serdes. It can also re-issue
//   the last transaction periodically (poll mode). Read data is published
//   atomically, and only when a read completes without a NACK.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   cmd[31:0]      go[31] rw[30] poll_en[29] nbytes-1[25:24] dev[22:16] reg[15:8]
//   wdata          write bytes; byte N-1 is sent first
//   rdata          read bytes; the first received byte lands in byte N-1
//   busy, done     transaction active / one-cycle end pulse
//   nack_err       sticky NACK flag, cleared when the next transaction starts
//   xfer_count     completed transactions (NACKed ones included)
//   step, tx_byte, step_valid   op request to the serdes, held until ready
//   rx_byte, ready, ack         op completion from the serdes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a go edge
// ADDR_W    | START + {dev,0}
// REG       | SEND register address
// DATA_W    | SEND write bytes, byte N-1 down to byte 0
// RADDR     | repeated START + {dev,1}
// READ      | READ_ACK for all but the last byte, READ_NACK for the last
// STOP      | STOP (also the exit path after any NACK)
// DONE      | done pulse; choose IDLE or WAIT_POLL from live poll_en
// WAIT_POLL | count down the poll interval, then rerun the latched command

module i2c_reg_sequencer #(
   parameter int MAX_BYTES   = 4,
   parameter int POLL_CYCLES = 25_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            cmd,
   input  logic [8*MAX_BYTES-1:0] wdata,
   output logic [8*MAX_BYTES-1:0] rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   nack_err,
   output logic [15:0]            xfer_count,
   output logic [2:0]             step,
   output logic [7:0]             tx_byte,
   output logic                   step_valid,
   input  logic [7:0]             rx_byte,
   input  logic                   ready,
   input  logic                   ack
);

   localparam logic [2:0] OP_START   = 3'd0;
   localparam logic [2:0] OP_SEND    = 3'd1;
   localparam logic [2:0] OP_RD_ACK  = 3'd2;
   localparam logic [2:0] OP_RD_NACK = 3'd3;
   localparam logic [2:0] OP_STOP    = 3'd4;

   localparam logic [1:0]  MAX_M1    = 2'(MAX_BYTES - 1);
   localparam logic [31:0] POLL_LOAD = 32'(POLL_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_W, S_REG, S_DATA_W, S_RADDR, S_READ, S_STOP, S_DONE, S_WAIT_POLL
   } state_t;

   state_t state, state_n;

   logic                   go_prev;
   logic                   go_edge;
   logic                   rw_q;
   logic [6:0]             dev_q;
   logic [7:0]             reg_q;
   logic [1:0]             nm1_q;
   logic [1:0]             nm1_cmd;
   logic [8*MAX_BYTES-1:0] wdata_q;
   logic [8*MAX_BYTES-1:0] shadow;
   logic [1:0]             idx;
   logic [31:0]            poll_cnt;

   logic sv_n;
   logic latch_cmd;
   logic start_txn;
   logic set_nack;
   logic idx_dec;
   logic shadow_we;
   logic finish;

   logic unused_cmd_bits;
   assign unused_cmd_bits = ^{cmd[28:26], cmd[23], cmd[7:0]};

   assign go_edge = cmd[31] & ~go_prev;
   // Byte counts beyond the configured width are clamped.
   assign nm1_cmd = (cmd[25:24] > MAX_M1) ? MAX_M1 : cmd[25:24];

   // Op states share one handshake: a state entered with step_valid low
   // presents its op next cycle; ready drops step_valid for one idle cycle.
   always_comb begin
      state_n   = state;
      sv_n      = step_valid;
      latch_cmd = 1'b0;
      start_txn = 1'b0;
      set_nack  = 1'b0;
      idx_dec   = 1'b0;
      shadow_we = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (go_edge) begin
               latch_cmd = 1'b1;
               start_txn = 1'b1;
               sv_n      = 1'b1;
               state_n   = S_ADDR_W;
            end
         end
         S_ADDR_W, S_REG, S_DATA_W, S_RADDR: begin
            if (!step_valid) begin
               sv_n = 1'b1;
            end else if (ready) begin
               sv_n = 1'b0;
               if (!ack) begin
                  set_nack = 1'b1;
                  state_n  = S_STOP;
               end else begin
                  case (state)
                     S_ADDR_W: state_n = S_REG;
                     S_REG:    state_n = rw_q ? S_RADDR : S_DATA_W;
                     S_RADDR:  state_n = S_READ;
                     default: begin
                        if (idx == 2'd0) state_n = S_STOP;
                        else             idx_dec = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_READ: begin
            if (!step_valid) begin
               sv_n = 1'b1;
            end else if (ready) begin
               sv_n      = 1'b0;
               shadow_we = 1'b1;
               if (idx == 2'd0) state_n = S_STOP;
               else             idx_dec = 1'b1;
            end
         end
         S_STOP: begin
            if (!step_valid) begin
               sv_n = 1'b1;
            end else if (ready) begin
               sv_n    = 1'b0;
               finish  = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = cmd[29] ? S_WAIT_POLL : S_IDLE;
         end
         S_WAIT_POLL: begin
            if (go_edge) begin
               latch_cmd = 1'b1;
               start_txn = 1'b1;
               sv_n      = 1'b1;
               state_n   = S_ADDR_W;
            end else if (!cmd[29]) begin
               state_n = S_IDLE;
            end else if (poll_cnt == 32'd0) begin
               start_txn = 1'b1;
               sv_n      = 1'b1;
               state_n   = S_ADDR_W;
            end
         end
         default: begin
            sv_n    = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

   always_comb begin
      step    = OP_START;
      tx_byte = 8'h00;
      case (state)
         S_ADDR_W: begin
            step    = OP_START;
            tx_byte = {dev_q, 1'b0};
         end
         S_REG: begin
            step    = OP_SEND;
            tx_byte = reg_q;
         end
         S_DATA_W: begin
            step    = OP_SEND;
            tx_byte = wdata_q[{idx, 3'b000} +: 8];
         end
         S_RADDR: begin
            step    = OP_START;
            tx_byte = {dev_q, 1'b1};
         end
         S_READ:  step = (idx == 2'd0) ? OP_RD_NACK : OP_RD_ACK;
         S_STOP:  step = OP_STOP;
         default: step = OP_START;
      endcase
   end

   assign busy = (state == S_ADDR_W) || (state == S_REG) || (state == S_DATA_W) ||
                 (state == S_RADDR) || (state == S_READ) || (state == S_STOP);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         step_valid <= 1'b0;
      end else begin
         state      <= state_n;
         step_valid <= sv_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         go_prev    <= 1'b0;
         rw_q       <= 1'b0;
         dev_q      <= '0;
         reg_q      <= '0;
         nm1_q      <= '0;
         wdata_q    <= '0;
         shadow     <= '0;
         rdata      <= '0;
         idx        <= '0;
         nack_err   <= 1'b0;
         xfer_count <= '0;
         poll_cnt   <= '0;
      end else begin
         go_prev <= cmd[31];
         if (latch_cmd) begin
            rw_q    <= cmd[30];
            dev_q   <= cmd[22:16];
            reg_q   <= cmd[15:8];
            nm1_q   <= nm1_cmd;
            wdata_q <= wdata;
         end
         // Data and read phases are exclusive, so one index serves both.
         if (start_txn)    idx <= latch_cmd ? nm1_cmd : nm1_q;
         else if (idx_dec) idx <= idx - 2'd1;
         if (start_txn)     nack_err <= 1'b0;
         else if (set_nack) nack_err <= 1'b1;
         if (shadow_we) shadow[{idx, 3'b000} +: 8] <= rx_byte;
         if (finish) begin
            xfer_count <= xfer_count + 16'd1;
            if (rw_q && !nack_err) rdata <= shadow;
         end
         if (state == S_DONE)
            poll_cnt <= POLL_LOAD;
         else if (state == S_WAIT_POLL && poll_cnt != 32'd0)
            poll_cnt <= poll_cnt - 32'd1;
      end
   end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Parametrised I2C register-transaction sequencer that sits between the PC command wires and the byte-level I2C serdes. It replaces the single-purpose temperature-sensor controller. It runs complete register writes and reads of 1 to MAX_BYTES data bytes to any 7-bit device address, with repeated-start reads and NACK abort. It also has an optional free-running poll mode that re-issues the last transaction periodically. Read results are presented atomically to the PC wire-out.

## Interface
- MAX_BYTES, 4: maximum data bytes per transaction (1..4).
- POLL_CYCLES, 25_000_000: clk cycles from end of one poll transaction to start of the next.
- clk  in  1  system clock (differential-buffered board clock).
- rst  in  1  asynchronous, active-high reset.
- cmd  in  32  PC wire-in.
  - [31] go: rising edge starts a transaction.
  - [30] rw: 1 = read.
  - [29] poll_en.
  - [25:24] nbytes-1.
  - [22:16] dev_addr.
  - [15:8] reg_addr.
- wdata  in  8*MAX_BYTES  write bytes; byte nbytes-1 is sent first (MSB first).
- rdata  out  8*MAX_BYTES  read bytes; first received byte lands in the highest used byte.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- nack_err  out  1  sticky; cleared at the next transaction start.
- xfer_count  out  16  completed transactions, wraps at 0xFFFF→0.
- step  out  3  serdes op: 0 START+send, 1 SEND, 2 READ_ACK, 3 READ_NACK, 4 STOP.
- tx_byte  out  8  byte for START/SEND.
- step_valid  out  1  op request.
- rx_byte  in  8  byte returned by READ ops.
- ready  in  1  one-cycle pulse, op complete.
- ack  in  1  slave ACK for START/SEND; valid only with ready.

## Operation
- States: IDLE, ADDR_W, REG, DATA_W, RADDR, READ, STOP, DONE, WAIT_POLL.
- Write sequence: ADDR_W(START, {dev,0}) → REG(SEND reg) → DATA_W(SEND ×N) → STOP.
- Read sequence: ADDR_W → REG → RADDR(START, {dev,1}, repeated start) → READ(READ_ACK ×(N-1), then READ_NACK) → STOP.
- N = nbytes-1 + 1. Values of N above MAX_BYTES are clamped to MAX_BYTES.
- cmd fields are latched at the go edge. Changes to cmd while busy are ignored, except poll_en, which is sampled at DONE.
- ack=0 on any ADDR_W/REG/DATA_W/RADDR step: set nack_err, go directly to STOP (STOP is always issued), and leave rdata unchanged.
- Received bytes go into a shadow register. rdata is loaded from the shadow at DONE, and only for a successful read.
- DONE: pulse done, increment xfer_count (NACKed transactions included), then return to IDLE.
  - If poll_en=1, go to WAIT_POLL instead of IDLE. WAIT_POLL counts POLL_CYCLES cycles, then reruns the latched transaction.
  - poll_en=0 seen in WAIT_POLL returns to IDLE at once.
- A go edge is accepted in IDLE or WAIT_POLL; in WAIT_POLL it relatches cmd and starts immediately. Go edges while busy are dropped and not queued.
- Edge detection keeps the previous go bit. The register resets to 0, so a go=1 held through reset starts one transaction after reset is released.

## Timing
- Reset values: every output 0; state IDLE; shadow register and poll counter 0.
- Reset mid-transaction: outputs drop to 0 immediately (asynchronous). No STOP is issued; the serdes is responsible for recovering its own bus.
- Go edge in cycle t: busy=1, step_valid=1 with step=0 and tx_byte={dev,0} at t+1.
- Handshake: step, tx_byte and step_valid are held stable until ready.
  - step_valid is low in the cycle after ready.
  - The next op is presented in the cycle after that, giving one idle cycle between ops.
  - ready while step_valid=0 is ignored.
- ack and rx_byte are sampled on the ready cycle.
- Ready of STOP in cycle t: done=1 at t+1, busy=0 at t+1, rdata and xfer_count updated at t+1, step_valid=0.
- Poll restart: busy rises POLL_CYCLES+1 cycles after the done pulse.
- nack_err clears in the same cycle busy rises.

## Test plan
- Read, dev 0x4B, reg 0x00, N=2, serdes returns 0x0C then 0x80 with ack=1:
  - ops are START 0x96, SEND 0x00, START 0x97, READ_ACK, READ_NACK, STOP;
  - rdata[15:0]=0x0C80, done pulse, xfer_count=1.
- Write, dev 0x4B, reg 0x03, N=1, wdata[7:0]=0x80: ops are START 0x96, SEND 0x03, SEND 0x80, STOP; nack_err=0.
- NACK on the first START (ack=0): next op is STOP; nack_err=1; rdata keeps its previous 0x0C80; xfer_count increments.
- Poll mode with POLL_CYCLES=100, N=2 read: second transaction starts exactly 101 cycles after done. Clearing poll_en in WAIT_POLL returns the block to IDLE with no further START.
- Extra go edge mid-transaction is ignored, and only one done pulse occurs. A go edge in WAIT_POLL with rw=0 starts a write immediately.
- Assert rst during READ: all outputs 0 at once. After release, a new go edge runs a full, correct read.
